// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable sequence detector: config port, serial
// stream input and status outputs.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               x;
  logic               cnt_clr;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, x, cnt_clr,
    input  y, match_cnt, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, x, cnt_clr,
    output y, match_cnt, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector with run-time pattern/length/
// overlap config, registered one-cycle match pulse and saturating counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_detect_prog_if.slave  bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic {ST_IDLE, ST_HIT} state_t;

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               ovl_reg, ovl_next;
  logic               err_reg, err_next;
  logic [MAX_LEN-1:0] hist_reg, hist_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic               y_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;

  // Only the low len bits of history/pattern take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  assign hist_shift = {hist_reg[MAX_LEN-2:0], bus.x};
  assign fill_inc   = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;
  assign match      = !err_reg && (fill_inc >= len_reg) &&
                      (((hist_shift ^ pat_reg) & len_mask) == '0);

  always_comb begin
    state_next = ST_IDLE;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    err_next   = err_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    cnt_next   = cnt_reg;

    if (bus.cfg_we) begin
      pat_next  = bus.cfg_pattern;
      len_next  = bus.cfg_len;
      ovl_next  = bus.cfg_overlap;
      err_next  = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));
      hist_next = '0;
      fill_next = '0;
    end else if (bus.in_valid) begin
      hist_next = hist_shift;
      fill_next = fill_inc;
      if (match) begin
        state_next = ST_HIT;
        // Non-overlap mode demands len fresh bits before the next match.
        if (!ovl_reg) begin
          fill_next = '0;
        end
      end
    end

    if (bus.cnt_clr) begin
      cnt_next = '0;
    end else if ((state_reg == ST_HIT) && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      ovl_reg   <= 1'b0;
      err_reg   <= 1'b1;
      hist_reg  <= '0;
      fill_reg  <= '0;
      y_reg     <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      ovl_reg   <= ovl_next;
      err_reg   <= err_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      y_reg     <= (state_reg == ST_HIT);
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.y         = y_reg;
  assign bus.match_cnt = cnt_reg;
  assign bus.cfg_err   = err_reg;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: two instances (8-bit and 2-bit counter)
// share one stream and are checked every cycle against a bit-list model.
module tb_seq_detect_prog;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus_a ();
  seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus_b ();

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    int y;
    int cnt_a;
    int cnt_b;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: list of bits received since the last restart
  int   m_hit, m_cnt_a, m_cnt_b, m_err, m_len, m_ovl, m_fill, m_pat;
  bit   m_bits[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hit = 0; m_cnt_a = 0; m_cnt_b = 0; m_err = 1;
    m_len = 0; m_ovl = 0; m_fill = 0; m_pat = 0;
    m_bits.delete();
  endtask

  task automatic model_edge(input int we, input int p, input int l, input int o,
                            input int v, input int xb, input int clr);
    int y_new;
    int match;
    y_new = m_hit;
    if (clr != 0) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (m_hit != 0) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3)   m_cnt_b++;
    end
    if (we != 0) begin
      m_pat  = p & ((1 << MAX_LEN) - 1);
      m_len  = l & ((1 << LEN_W) - 1);
      m_ovl  = o & 1;
      m_err  = (m_len == 0 || m_len > MAX_LEN) ? 1 : 0;
      m_bits.delete();
      m_fill = 0;
      m_hit  = 0;
    end else if (v != 0) begin
      m_bits.push_back(bit'(xb & 1));
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      if (m_fill < MAX_LEN) m_fill++;
      match = (m_err == 0 && m_fill >= m_len) ? 1 : 0;
      if (match != 0) begin
        for (int i = 0; i < m_len; i++) begin
          if (int'(m_bits[m_bits.size() - 1 - i]) != ((m_pat >> i) & 1)) match = 0;
        end
      end
      m_hit = match;
      if (match != 0 && m_ovl == 0) m_fill = 0;
    end else begin
      m_hit = 0;
    end
    exp_q.push_back('{y: y_new, cnt_a: m_cnt_a, cnt_b: m_cnt_b, err: m_err});
  endtask

  task automatic drive(input int we, input int p, input int l, input int o,
                       input int v, input int xb, input int clr);
    logic [MAX_LEN-1:0] pv;
    logic [LEN_W-1:0]   lv;
    pv = MAX_LEN'(p);
    lv = LEN_W'(l);
    bus_a.cfg_we = we[0]; bus_a.cfg_pattern = pv; bus_a.cfg_len = lv; bus_a.cfg_overlap = o[0];
    bus_a.in_valid = v[0]; bus_a.x = xb[0]; bus_a.cnt_clr = clr[0];
    bus_b.cfg_we = we[0]; bus_b.cfg_pattern = pv; bus_b.cfg_len = lv; bus_b.cfg_overlap = o[0];
    bus_b.in_valid = v[0]; bus_b.x = xb[0]; bus_b.cnt_clr = clr[0];
  endtask

  task automatic step(input int we, input int p, input int l, input int o,
                      input int v, input int xb, input int clr);
    drive(we, p, l, o, v, xb, clr);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('{y: 0, cnt_a: 0, cnt_b: 0, err: 1});
    end else begin
      model_edge(we, p, l, o, v, xb, clr);
    end
    #1;
  endtask

  task automatic cfg(input int p, input int l, input int o);
    step(1, p, l, o, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_cnt();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  // Feed n bits of val, most significant of the n first
  task automatic feed(input int val, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, 0, 0, 0, 1, (val >> i) & 1, 0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("async_rst_y", int'(bus_a.y), 0);
    chk("async_rst_cnt", int'(bus_a.match_cnt), 0);
    chk("async_rst_err", int'(bus_a.cfg_err), 1);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("y", int'(bus_a.y), e.y);
        chk("cnt8", int'(bus_a.match_cnt), e.cnt_a);
        chk("cnt2", int'(bus_b.match_cnt), e.cnt_b);
        chk("cfg_err", int'(bus_a.cfg_err), e.err);
        chk("y_b", int'(bus_b.y), e.y);
        if (bus_a.y) $display("match pulse t=%0t cnt8=%0d cnt2=%0d", $time, bus_a.match_cnt, bus_b.match_cnt);
      end
    end
  end

  initial begin
    int len, pat, ovl, wait_cnt;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // 0100 non-overlap, then overlap, on 0,1,0,0,1,0,0
    cfg(4'b0100, 4, 0); feed(7'b0100100, 7); idle(3); clear_cnt();
    cfg(4'b0100, 4, 1); feed(7'b0100100, 7); idle(3); clear_cnt();

    // len=1 back-to-back, 2-bit counter saturates
    cfg(1, 1, 1); feed(5'b11111, 5); idle(3); clear_cnt();

    // gaps between valid bits
    cfg(4'b0100, 4, 0);
    for (int i = 3; i >= 0; i--) begin
      step(0, 0, 0, 0, 1, (4 >> i) & 1, 0);
      idle(2);
    end
    idle(2);

    // config rewrite after 3 bits restarts the fill
    cfg(4'b0100, 4, 0); feed(3'b010, 3); cfg(4'b0100, 4, 0); feed(1'b0, 1); idle(2);
    feed(4'b0100, 4); idle(3); clear_cnt();

    // illegal lengths disable detection
    cfg(0, 0, 1); for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, $urandom_range(0, 1), 0);
    cfg(1, MAX_LEN + 1, 1); for (int i = 0; i < 20; i++) feed(1, 1);
    idle(2);

    // full-width pattern
    cfg(8'hA5, 8, 0); feed(8'h5A, 4); feed(8'hA5, 8); feed(8'hA5, 8); idle(3); clear_cnt();

    // async reset between 3rd and 4th bit
    cfg(4'b0100, 4, 0); feed(3'b010, 3);
    async_reset(); idle(1); rst_n = 1'b1;
    feed(1'b0, 1); idle(3);

    // cnt_clr coincides with hit; cfg_we beats in_valid; cfg on pending hit
    cfg(1, 1, 1); feed(1, 1); clear_cnt(); idle(2);
    step(1, 1, 1, 1, 1, 1, 0); idle(2);
    feed(1, 1); cfg(3, 2, 0); idle(3);

    // 8-bit counter saturation
    cfg(1, 1, 1); feed(1, 1);
    for (int i = 0; i < 300; i++) feed(1, 1);
    idle(3); clear_cnt();

    // randomized configs and streams
    for (int r = 0; r < 40; r++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
      pat = $urandom_range(0, 255);
      ovl = $urandom_range(0, 1);
      cfg(pat, len, ovl);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 49) == 0)
          step(1, pat, len, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
        else
          step(0, 0, 0, 0, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
               ($urandom_range(0, 49) == 0) ? 1 : 0);
      end
    end
    idle(3);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-sequence detector: the parametrised successor to our fixed-pattern Moore detectors. Pattern, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded at run time through a config port. The block sits on a valid-qualified serial bit stream and emits a registered one-cycle match pulse plus a saturating match counter for status readback.

## Interface

- MAX_LEN, 8: maximum pattern length in bits (≥2)
- CNT_W, 8: width of match counter
- LEN_W, $clog2(MAX_LEN+1): width of length field (derived, not overridden)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe, one cycle
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- in_valid  in  1  qualifies x
- x  in  1  serial data bit
- cnt_clr  in  1  synchronous clear of match_cnt
- y  out  1  match pulse, registered
- match_cnt  out  CNT_W  saturating count of matches
- cfg_err  out  1  high while stored cfg_len is 0 or > MAX_LEN

## Operation

- Registers: pat, len, ovl (config); hist[MAX_LEN-1:0] shift history; fill (0..MAX_LEN) bits accepted since last restart; hit (internal Moore "match" state); y; match_cnt.
- Reset: pat=0, len=0, ovl=0, hist=0, fill=0, hit=0, y=0, match_cnt=0, cfg_err=1 (len=0 is illegal).
- Config write (cfg_we=1): latch pat/len/ovl; clear hist, fill, hit. y still takes the old hit value on that edge. match_cnt is untouched. cfg_err = (cfg_len==0) || (cfg_len>MAX_LEN), registered with the config.
- Bit accept (in_valid=1, cfg_we=0): hist <= {hist[MAX_LEN-2:0], x}; fill <= min(fill+1, MAX_LEN).
- Match condition is evaluated on the post-shift values: new_fill ≥ len, and new_hist[len-1:0] == pat[len-1:0]. Bits at or above len are ignored. cfg_err forces no match.
- On match: hit <= 1.
  - Non-overlap mode: fill <= 0, so the next match needs len fresh bits.
  - Overlap mode: fill is not reset.
- Any other edge: hit <= 0. hit is high for exactly one cycle per match.
- y <= hit on every edge (Moore output stage).
- match_cnt increments when hit=1 and saturates at 2^CNT_W−1. cnt_clr has priority: when cnt_clr and hit coincide, the result is 0.
- in_valid=0: hist and fill hold. hit still clears, so a stall never stretches y.
- x is don't-care when in_valid=0.

## Timing

- Latency: final pattern bit is sampled at edge k; hit is high after edge k; y is high for one cycle after edge k+1 (2-edge latency).
- match_cnt updates at edge k+1, the same edge y rises.
- Back-to-back matches in overlap mode with len=1 give y high on consecutive cycles.
- cfg_we together with in_valid: config wins and the data bit is dropped.
- A config write on edge k+1 while hit=1 still produces the pending y pulse and count.
- Asynchronous reset mid-stream clears everything immediately. Detection restarts with len=0 (disabled) until reconfigured.
- No combinational path from any input to any output.

## Test plan

- Config pat=0100, len=4, ovl=0; stream 0,1,0,0,1,0,0 (all valid) -> exactly one y pulse, two cycles after the 4th bit; match_cnt=1.
- Same stream with ovl=1 -> two y pulses, two cycles after bits 4 and 7; match_cnt=2.
- len=1, pat=1, ovl=1; stream 1,1,1 -> y high on 3 consecutive cycles; match_cnt=3. Repeat with CNT_W=2 and 5 ones -> match_cnt saturates at 3.
- pat=0100, len=4; insert in_valid=0 gaps between the bits of 0100 -> one match; y is one cycle wide and occurs two edges after the last valid bit. Separately, a cfg_we pulse after 3 bits -> no match until 4 new bits arrive.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1 and no y for any stream. Set MAX_LEN=8, pat=8'hA5, len=8 -> a match occurs only after ≥8 bits.
- Assert rst_n low between the 3rd and 4th bit of 0100 -> y=0, match_cnt=0, cfg_err=1. Assert cnt_clr together with a hit -> match_cnt=0.
